mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port 16-bit RAM between two requesters: port 0 (CPU fetch/data) and port 1 (loader/DMA).
//   Round-robin arbitration, at most one access per cycle.
//   Tracks outstanding reads through a READ_LAT-deep pipeline and returns read data only to the port that issued the read.
//   Sits between rcpu/loader and RAM in the top-level and in testbenches.
// PARAMETERS
//   ADDR_W    16  address width, all ports
//   DATA_W    16  data width, all ports
//   READ_LAT  1   RAM cycles from address presented to mem_rdata valid (1..4)
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       synchronous reset, active-high
//   r0_req     in   1       port 0 access request
//   r0_we      in   1       port 0: 1=write, 0=read
//   r0_addr    in   ADDR_W  port 0 address
//   r0_wdata   in   DATA_W  port 0 write data
//   r0_gnt     out  1       port 0 access accepted this cycle
//   r0_rvalid  out  1       port 0 read data valid
//   r0_rdata   out  DATA_W  port 0 read data
//   r1_*       --   --      identical set for port 1
//   mem_addr   out  ADDR_W  RAM address
//   mem_we     out  1       RAM write enable
//   mem_wdata  out  DATA_W  RAM write data
//   mem_rdata  in   DATA_W  RAM read data, valid READ_LAT cycles after address
// BEHAVIOUR
//   Reset
//   - While rst=1: r0_gnt = r1_gnt = 0 and mem_we = 0 (forced combinationally).
//   - Next edge: rvalid pipeline cleared; prio pointer = 0 (port 0 wins first tie).
//   - After reset, r*_rvalid = 0 and mem_addr = 0 until the first grant.
//
//   Handshake
//   - Requester raises req with we/addr/wdata valid, and holds them stable until it samples gnt=1 at a rising edge.
//   - The access is performed in the cycle where gnt=1.
//   - Requester may drop or change req the cycle after gnt.
//   - Back-to-back accesses: req stays high and the next request is presented immediately.
//
//   Arbitration (combinational, zero-latency grant)
//   - Only one req: that port is granted.
//   - Both req: port == prio is granted.
//   - On any grant edge, prio <= !granted_port. Alternation is strict under continuous contention: 0,1,0,1...
//   - No req: no grant; prio unchanged.
//   - At most one gnt is high in any cycle (checked by assertion).
//
//   Mux
//   - mem_addr/mem_we/mem_wdata are driven from the granted port.
//   - When idle: mem_we = 0, mem_addr = 0, mem_wdata = 0.
//
//   Reads
//   - A granted read pushes {valid=1, owner} into a READ_LAT-stage shift register.
//   - A write or idle cycle pushes valid=0.
//   - Stage READ_LAT-1 drives rvalid of the owner port only.
//   - r0_rdata = r1_rdata = mem_rdata: latency READ_LAT cycles from the gnt edge; qualify with rvalid.
//   - Pipelined reads from alternating ports are returned in issue order, one per cycle, with no bubbles.
//
//   Boundaries
//   - Reset mid-read: in-flight rvalids are discarded, never delivered.
//   - Write then read of the same address on consecutive cycles: returns the new value (RAM ordering, no bypass).
//   - addr 0xFFFF passes unmodified (no wrap logic).
// STRUCTURE
//   - rcpu_mem_pkg (shared): ADDR_W/DATA_W defaults, PORT_CPU=0, PORT_DMA=1, owner-tag type.
//   - One sub-module, rr_arb2: 2-way round-robin (req[1:0], rst, clk -> gnt[1:0], prio flop).
//   - Read-tracking pipeline and mux stay in mem_arbiter.
// TESTING
//   1. Reset
//      Stimulus: rst=1 for 2 cycles with both req=1.
//      Required: gnt=00 and mem_we=0 throughout; after release, port 0 is granted first.
//   2. Single write/read
//      Stimulus: r0 writes 0x1234 @0x0010, then r0 reads @0x0010.
//      Required: r0_gnt each cycle; r0_rvalid=1 with r0_rdata=0x1234 exactly READ_LAT cycles after the read grant; r1_rvalid stays 0.
//   3. Contention
//      Stimulus: both ports read continuously for 6 cycles (r0 @0x0000+, r1 @0x0100+).
//      Required: grants alternate 0,1,0,1,0,1; each port gets 3 rvalids carrying its own data, in order.
//   4. Hold stability
//      Stimulus: r1 holds req while r0 has prio and r0 gets 2 grants.
//      Required: r1 is granted by the second contended cycle; addr/wdata unchanged until then; no lost or duplicated access.
//   5. Reset mid-flight
//      Stimulus: READ_LAT=2, r0 read granted, rst=1 on the next cycle.
//      Required: no rvalid is ever asserted for that read.
//   6. Mixed traffic
//      Stimulus: r0 write 0xBEEF @0x0020 and r1 read @0x0020 in the same cycle, prio=0.
//      Required: write first; r1 read next cycle returns 0xBEEF.

Source files
------------

// File: rtl/rcpu_mem_pkg.sv
// Shared definitions for the RAM arbiter: default widths, port identities and
// the owner tag carried alongside each in-flight read.
package rcpu_mem_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef logic owner_t;
  localparam owner_t PORT_CPU = 1'b0;
  localparam owner_t PORT_DMA = 1'b1;

  typedef struct packed {
    logic   vld;
    owner_t owner;
  } rd_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a zero-latency grant.
// The priority pointer flips to the other port whenever a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req[0] && (!req[1] || !prio)) gnt = 2'b01;
      else if (req[1])                  gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         prio <= 1'b0;
    else if (gnt[0]) prio <= 1'b1;
    else if (gnt[1]) prio <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ($onehot0(gnt));
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port RAM between the CPU port (0) and the loader/DMA port (1),
// tracking outstanding reads so returned data is flagged only to its issuer.
module mem_arbiter
  import rcpu_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [1:0] req, gnt;
  assign req = {r1_req, r0_req};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign r0_gnt = gnt[PORT_CPU];
  assign r1_gnt = gnt[PORT_DMA];

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gnt[PORT_CPU]) begin
      mem_addr  = r0_addr;
      mem_we    = r0_we;
      mem_wdata = r0_wdata;
    end else if (gnt[PORT_DMA]) begin
      mem_addr  = r1_addr;
      mem_we    = r1_we;
      mem_wdata = r1_wdata;
    end
  end

  // One tag per cycle enters the pipe so the tail lines up with mem_rdata.
  rd_tag_t [READ_LAT-1:0] vld_pipe;
  rd_tag_t                push, tail;

  assign push.vld   = (|gnt) && !mem_we;
  assign push.owner = gnt[PORT_DMA];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= push;
      for (int i = 1; i < READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign tail = vld_pipe[READ_LAT-1];

  // Masked during reset so a read caught by reset is never reported.
  assign r0_rvalid = !rst && tail.vld && (tail.owner == PORT_CPU);
  assign r1_rvalid = !rst && tail.vld && (tail.owner == PORT_DMA);
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with READ_LAT=2 and a behavioural RAM whose
// unwritten words hold addr ^ 16'h5A5A.
module tb_mem_arbiter;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [15:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [15:0] r1_addr, r1_wdata, r1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(RL)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  logic [15:0] ram [int];
  logic [15:0] rq  [RL];

  always @(posedge clk) begin
    rq[0] <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pat(mem_addr);
    for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
  end
  assign mem_rdata = rq[RL-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic q0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic q1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rv(input string tag, input logic e0, input logic e1);
    chk({tag, "_r0v"}, 32'(r0_rvalid), 32'(e0));
    chk({tag, "_r1v"}, 32'(r1_rvalid), 32'(e1));
  endtask

  logic [15:0] n0, n1;

  initial begin
    // reset with both ports requesting writes
    rst = 1'b1;
    drive(1, 1, 16'h0030, 16'h1111, 1, 1, 16'h0031, 16'h2222);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", 32'({r1_gnt, r0_gnt}), 32'h0);
      chk("rst_we", 32'(mem_we), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_gnt", 32'({r1_gnt, r0_gnt}), 32'h1);
    chk("rel_addr", 32'(mem_addr), 32'h0030);
    chk_rv("rel", 0, 0);
    tick();

    idle();
    @(negedge clk);
    chk("idle_gnt", 32'({r1_gnt, r0_gnt}), 32'h0);
    chk("idle_addr", 32'(mem_addr), 32'h0);
    chk("idle_we", 32'(mem_we), 32'h0);
    chk("idle_wdata", 32'(mem_wdata), 32'h0);
    tick();

    // single write then read by port 0
    drive(1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("wr_gnt", 32'({r1_gnt, r0_gnt}), 32'h1);
    chk("wr_we", 32'(mem_we), 32'h1);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rd_gnt", 32'({r1_gnt, r0_gnt}), 32'h1);
    chk("rd_we", 32'(mem_we), 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk_rv("rd_lat1", 0, 0);
    tick();
    @(negedge clk);
    chk_rv("rd_lat2", 1, 0);
    chk("rd_data", 32'(r0_rdata), 32'h1234);
    tick();
    @(negedge clk);
    chk_rv("rd_after", 0, 0);
    tick();

    // port 1 write at the top address; leaves prio on port 0
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'hFFFF, 16'h7777);
    @(negedge clk);
    chk("ffff_gnt", 32'({r1_gnt, r0_gnt}), 32'h2);
    chk("ffff_addr", 32'(mem_addr), 32'hFFFF);
    tick();

    // continuous contention, both ports reading
    n0 = 16'h0000;
    n1 = 16'h0100;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) drive(1, 0, n0, 16'h0, 1, 0, n1, 16'h0);
      else idle();
      @(negedge clk);
      if (k < 6) chk("cont_gnt", 32'({r1_gnt, r0_gnt}), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 2) begin
        chk_rv("cont", ((k - 2) % 2 == 0), ((k - 2) % 2 == 1));
        chk("cont_data", 32'(r0_rdata),
            32'(pat(16'(((k - 2) % 2 == 0 ? 16'h0000 : 16'h0100) + 16'((k - 2) / 2)))));
      end else begin
        chk_rv("cont_pre", 0, 0);
      end
      if (r0_gnt) n0++;
      else if (r1_gnt) n1++;
      tick();
    end

    // port 1 holds a write while port 0 streams two writes
    drive(1, 1, 16'h0040, 16'hAAAA, 1, 1, 16'h0155, 16'hCAFE);
    @(negedge clk);
    chk("hold1_gnt", 32'({r1_gnt, r0_gnt}), 32'h1);
    chk("hold1_addr", 32'(mem_addr), 32'h0040);
    tick();
    drive(1, 1, 16'h0041, 16'hBBBB, 1, 1, 16'h0155, 16'hCAFE);
    @(negedge clk);
    chk("hold2_gnt", 32'({r1_gnt, r0_gnt}), 32'h2);
    chk("hold2_addr", 32'(mem_addr), 32'h0155);
    chk("hold2_wdata", 32'(mem_wdata), 32'hCAFE);
    tick();
    drive(1, 1, 16'h0041, 16'hBBBB, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("hold3_gnt", 32'({r1_gnt, r0_gnt}), 32'h1);
    chk("hold3_wdata", 32'(mem_wdata), 32'hBBBB);
    tick();
    // read the three locations back through port 0
    drive(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0);
    tick();
    drive(1, 0, 16'h0041, 16'h0, 0, 0, 16'h0, 16'h0);
    tick();
    drive(1, 0, 16'h0155, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk_rv("hold_rb0", 1, 0);
    chk("hold_rb0_data", 32'(r0_rdata), 32'hAAAA);
    tick();
    idle();
    @(negedge clk);
    chk_rv("hold_rb1", 1, 0);
    chk("hold_rb1_data", 32'(r0_rdata), 32'hBBBB);
    tick();
    @(negedge clk);
    chk_rv("hold_rb2", 1, 0);
    chk("hold_rb2_data", 32'(r0_rdata), 32'hCAFE);
    tick();

    // bring prio back to port 0
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0201, 16'h0);
    tick();

    // same-cycle write (port 0) and read (port 1) of one address
    drive(1, 1, 16'h0020, 16'hBEEF, 1, 0, 16'h0020, 16'h0);
    @(negedge clk);
    chk("mix1_gnt", 32'({r1_gnt, r0_gnt}), 32'h1);
    chk("mix1_we", 32'(mem_we), 32'h1);
    tick();
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
    @(negedge clk);
    chk("mix2_gnt", 32'({r1_gnt, r0_gnt}), 32'h2);
    chk("mix2_addr", 32'(mem_addr), 32'h0020);
    tick();
    idle();
    @(negedge clk);
    chk_rv("mix_lat1", 0, 0);
    tick();
    @(negedge clk);
    chk_rv("mix_lat2", 0, 1);
    chk("mix_data", 32'(r1_rdata), 32'hBEEF);
    tick();

    // reset one cycle after a read grant
    drive(1, 0, 16'h0000, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("midrst_gnt", 32'({r1_gnt, r0_gnt}), 32'h1);
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk_rv("midrst_a", 0, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_rv("midrst_b", 0, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
